// File: rtl/cic_pkg.sv
// Shared types and defaults for the CIC run-time sequencer.
package cic_pkg;

    localparam int unsigned RATIO_W       = 16;
    localparam int unsigned DATA_W        = 8;
    localparam int unsigned DEFAULT_RATIO = 12500;
    localparam int unsigned MIN_RATIO     = 2;

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_FLUSH = 2'd1,
        S_RUN   = 2'd2
    } state_e;

endpackage

// File: rtl/cic_ctrl_if.sv
// Ratio configuration handshake between a config master and the CIC sequencer.
interface cic_ctrl_if #(
    parameter int unsigned RATIO_W = cic_pkg::RATIO_W
);
    logic [RATIO_W-1:0] cfg_ratio;
    logic               cfg_valid;
    logic               cfg_ready;
    logic               cfg_err;

    modport master (output cfg_ratio, output cfg_valid, input cfg_ready, input cfg_err);
    modport slave  (input cfg_ratio, input cfg_valid, output cfg_ready, output cfg_err);
endinterface

// File: rtl/cic_strobe_mon.sv
// CIC output strobe edge detector plus a saturating watchdog that times out when
// no edge arrives within 2*ratio+margin clocks.
module cic_strobe_mon #(
    parameter int unsigned RATIO_W     = 16,
    parameter int unsigned WDOG_MARGIN = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               strobe_i,
    input  logic               clr_i,
    input  logic [RATIO_W-1:0] ratio_i,
    output logic               strobe_edge_o,
    output logic               timeout_o
);
    localparam int unsigned CntW = RATIO_W + 2;

    logic            prev_q;
    logic [CntW-1:0] wdog_q, wdog_d, limit;

    assign strobe_edge_o = strobe_i & ~prev_q;
    assign limit         = {1'b0, ratio_i, 1'b0} + CntW'(WDOG_MARGIN);

    always_comb begin
        wdog_d = wdog_q;
        if (clr_i || strobe_edge_o) begin
            wdog_d = '0;
        end else if (wdog_q != '1) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    // Fires on the clock where the count reaches the limit.
    assign timeout_o = ~clr_i & (wdog_d >= limit);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
            wdog_q <= '0;
        end else begin
            prev_q <= strobe_i;
            wdog_q <= wdog_d;
        end
    end
endmodule

// File: rtl/cic_ctrl.sv
// Run-time sequencer for the CIC decimator: resets and flushes the CIC on each ratio
// change, qualifies decimated samples and recovers from a stalled output strobe.
module cic_ctrl #(
    parameter int unsigned RATIO_W        = cic_pkg::RATIO_W,
    parameter int unsigned DATA_W         = cic_pkg::DATA_W,
    parameter int unsigned DEFAULT_RATIO  = cic_pkg::DEFAULT_RATIO,
    parameter int unsigned MIN_RATIO      = cic_pkg::MIN_RATIO,
    parameter int unsigned RST_CYCLES     = 4,
    parameter int unsigned SETTLE_SAMPLES = 4,
    parameter int unsigned WDOG_MARGIN    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] d_in,
    cic_ctrl_if.slave                cfg,
    output logic                     cic_rst,
    output logic [RATIO_W-1:0]       cic_ratio,
    output logic signed [DATA_W-1:0] cic_d_in,
    input  logic signed [DATA_W-1:0] cic_d_out,
    input  logic                     cic_d_clk,
    output logic signed [DATA_W-1:0] d_out,
    output logic                     d_out_valid,
    output logic                     busy,
    output logic                     stall
);
    import cic_pkg::*;

    localparam int unsigned RstCntW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned SetCntW = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;

    state_e                   state_q, state_d;
    logic [RstCntW-1:0]       rst_cnt_q, rst_cnt_d;
    logic [SetCntW-1:0]       settle_q, settle_d;
    logic [RATIO_W-1:0]       ratio_q, ratio_d;
    logic signed [DATA_W-1:0] d_in_q, d_in_d, d_out_q, d_out_d;
    logic                     dv_q, dv_d, err_q, err_d, stall_q, stall_d;
    logic                     strobe_edge, timeout, xfer, legal, in_rst;

    assign in_rst        = (state_q == S_RST);
    assign cic_rst       = in_rst;
    assign busy          = (state_q != S_RUN);
    assign cfg.cfg_ready = (state_q == S_RUN);
    assign cfg.cfg_err   = err_q;
    assign xfer          = cfg.cfg_valid & cfg.cfg_ready;
    assign legal         = (cfg.cfg_ratio >= RATIO_W'(MIN_RATIO));

    assign cic_ratio   = ratio_q;
    assign cic_d_in    = d_in_q;
    assign d_out       = d_out_q;
    assign d_out_valid = dv_q;
    assign stall       = stall_q;

    cic_strobe_mon #(
        .RATIO_W     (RATIO_W),
        .WDOG_MARGIN (WDOG_MARGIN)
    ) u_strobe_mon (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .strobe_i      (cic_d_clk),
        .clr_i         (in_rst),
        .ratio_i       (ratio_q),
        .strobe_edge_o (strobe_edge),
        .timeout_o     (timeout)
    );

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        settle_d  = settle_q;
        ratio_d   = ratio_q;
        stall_d   = stall_q;
        d_out_d   = d_out_q;
        dv_d      = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            S_RST: begin
                if (rst_cnt_q == RstCntW'(RST_CYCLES - 1)) begin
                    state_d   = S_FLUSH;
                    rst_cnt_d = '0;
                    settle_d  = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            S_FLUSH: begin
                if (timeout) begin
                    stall_d = 1'b1;
                    state_d = S_RST;
                end else if (strobe_edge) begin
                    if (settle_q == SetCntW'(SETTLE_SAMPLES - 1)) begin
                        state_d = S_RUN;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                // An accepted ratio change wins over a coincident sample, which is dropped.
                if (xfer && legal) begin
                    ratio_d = cfg.cfg_ratio;
                    stall_d = 1'b0;
                    state_d = S_RST;
                end else begin
                    err_d = xfer;
                    if (timeout) begin
                        stall_d = 1'b1;
                        state_d = S_RST;
                    end else if (strobe_edge) begin
                        d_out_d = cic_d_out;
                        dv_d    = 1'b1;
                    end
                end
            end
            default: state_d = S_RST;
        endcase

        d_in_d = (state_d == S_RST) ? '0 : d_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RST;
            rst_cnt_q <= '0;
            settle_q  <= '0;
            ratio_q   <= RATIO_W'(DEFAULT_RATIO);
            d_in_q    <= '0;
            d_out_q   <= '0;
            dv_q      <= 1'b0;
            err_q     <= 1'b0;
            stall_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            settle_q  <= settle_d;
            ratio_q   <= ratio_d;
            d_in_q    <= d_in_d;
            d_out_q   <= d_out_d;
            dv_q      <= dv_d;
            err_q     <= err_d;
            stall_q   <= stall_d;
        end
    end
endmodule

// File: tb/tb_cic_ctrl.sv
// Directed bench for cic_ctrl with a behavioural CIC that strobes every cic_ratio clocks.
module tb_cic_ctrl;
    localparam int unsigned RW = 16;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] d_in, cic_d_in, cic_d_out, d_out;
    logic [RW-1:0] cic_ratio;
    logic          cic_rst, cic_d_clk, d_out_valid, busy, stall;

    cic_ctrl_if #(.RATIO_W(RW)) cfg ();

    cic_ctrl #(.DEFAULT_RATIO(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .d_in        (d_in),
        .cfg         (cfg),
        .cic_rst     (cic_rst),
        .cic_ratio   (cic_ratio),
        .cic_d_in    (cic_d_in),
        .cic_d_out   (cic_d_out),
        .cic_d_clk   (cic_d_clk),
        .d_out       (d_out),
        .d_out_valid (d_out_valid),
        .busy        (busy),
        .stall       (stall)
    );

    always #5 clk = ~clk;

    // Behavioural CIC: one-clock strobe every cic_ratio clocks, new sample on each strobe.
    logic          m_run;
    logic [RW-1:0] m_cnt;
    logic          m_strobe;
    logic [DW-1:0] m_val;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt    <= '0;
            m_strobe <= 1'b0;
            m_val    <= 8'h10;
        end else if (cic_rst) begin
            m_cnt    <= '0;
            m_strobe <= 1'b0;
        end else begin
            m_strobe <= 1'b0;
            if (m_run) begin
                if (m_cnt == cic_ratio - 1'b1) begin
                    m_cnt    <= '0;
                    m_strobe <= 1'b1;
                    m_val    <= m_val + 8'd3;
                end else begin
                    m_cnt <= m_cnt + 1'b1;
                end
            end
        end
    end

    assign cic_d_clk = m_strobe;
    assign cic_d_out = m_val;

    int            n_vec, n_err;
    int            nv, t;
    logic [DW-1:0] held;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cic_rst"}, cic_rst, 1);
        check({tag, "_ratio"}, cic_ratio, 8);
        check({tag, "_cic_d_in"}, cic_d_in, 0);
        check({tag, "_d_out"}, d_out, 0);
        check({tag, "_valid"}, d_out_valid, 0);
        check({tag, "_ready"}, cfg.cfg_ready, 0);
        check({tag, "_err"}, cfg.cfg_err, 0);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_stall"}, stall, 0);
    endtask

    // Call on the first cycle cic_rst is high; counts clocks it stays high.
    task automatic count_rst(input string tag);
        int n = 0;
        check({tag, "_din0"}, cic_d_in, 0);
        while (cic_rst && n < 40) begin
            n++;
            tick();
        end
        check({tag, "_len"}, n, 4);
    endtask

    // Ticks until n model strobes are seen; returns with the last strobe high.
    task automatic wait_strobes(input int n, input string tag, output int nvalid);
        int seen = 0;
        int tt = 0;
        nvalid = 0;
        while (seen < n && tt < 400) begin
            tick();
            tt++;
            if (d_out_valid) nvalid++;
            if (m_strobe) seen++;
        end
        check({tag, "_seen"}, seen, n);
    endtask

    task automatic expect_pulse(input string tag);
        logic [DW-1:0] exp_val = m_val;
        tick();
        check({tag, "_valid"}, d_out_valid, 1);
        check({tag, "_d_out"}, d_out, exp_val);
        tick();
        check({tag, "_valid_end"}, d_out_valid, 0);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!d_out_valid && n < 100);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        d_in = 8'd5;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_ratio = '0;
        m_run = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        check_reset("por");

        // Boot with the default ratio of 8.
        rst_n = 1'b1;
        count_rst("boot_rst");
        check("boot_flush_din", cic_d_in, 5);
        wait_strobes(4, "boot_settle", nv);
        check("boot_settle_novalid", nv, 0);
        wait_strobes(1, "boot_5th", nv);
        check("boot_5th_novalid", nv, 0);
        expect_pulse("boot_first");
        check("boot_ready", cfg.cfg_ready, 1);

        // Rejected ratio leaves everything running.
        cfg.cfg_ratio = 16'd1;
        cfg.cfg_valid = 1'b1;
        tick();
        cfg.cfg_valid = 1'b0;
        check("ill_err", cfg.cfg_err, 1);
        check("ill_ratio", cic_ratio, 8);
        check("ill_no_rst", cic_rst, 0);
        check("ill_ready", cfg.cfg_ready, 1);
        tick();
        check("ill_err_end", cfg.cfg_err, 0);
        wait_strobes(1, "ill_next", nv);
        expect_pulse("ill_stream");

        // Ratio 16 accepted on the same cycle as a strobe edge: sample dropped.
        wait_strobes(1, "coinc", nv);
        held = d_out;
        cfg.cfg_ratio = 16'd16;
        cfg.cfg_valid = 1'b1;
        tick();
        cfg.cfg_valid = 1'b0;
        check("coinc_novalid", d_out_valid, 0);
        check("coinc_ratio", cic_ratio, 16);
        check("coinc_ready", cfg.cfg_ready, 0);
        count_rst("r16_rst");
        check("r16_hold", d_out, held);
        wait_strobes(4, "r16_settle", nv);
        check("r16_settle_novalid", nv, 0);
        wait_strobes(1, "r16_5th", nv);
        expect_pulse("r16_first");
        wait_valid(t);
        check("r16_spacing", t, 15);
        check("r16_d_out", d_out, m_val);

        // Back to 8, then a request raised during flush is held until the first run cycle.
        cfg.cfg_ratio = 16'd8;
        cfg.cfg_valid = 1'b1;
        tick();
        cfg.cfg_valid = 1'b0;
        check("r8_ratio", cic_ratio, 8);
        count_rst("r8_rst");
        cfg.cfg_valid = 1'b1;
        wait_strobes(4, "hold_settle", nv);
        check("hold_novalid", nv, 0);
        check("hold_ready_low", cfg.cfg_ready, 0);
        tick();
        check("hold_run_ready", cfg.cfg_ready, 1);
        tick();
        cfg.cfg_valid = 1'b0;
        check("hold_xfer_rst", cic_rst, 1);
        check("hold_xfer_novalid", d_out_valid, 0);
        count_rst("hold_rst");

        // Stop the CIC strobes and let the watchdog fire.
        wait_strobes(4, "st_settle", nv);
        wait_strobes(1, "st_5th", nv);
        m_run = 1'b0;
        tick();
        check("st_last_valid", d_out_valid, 1);
        t = 0;
        while (!stall && t < 100) begin
            tick();
            t++;
        end
        check("st_delay", t, 32);
        check("st_rst", cic_rst, 1);
        check("st_ratio", cic_ratio, 8);
        m_run = 1'b1;
        count_rst("st_recover_rst");
        wait_strobes(4, "st_flush", nv);
        wait_strobes(1, "st_run", nv);
        expect_pulse("st_resume");
        check("st_sticky", stall, 1);
        cfg.cfg_ratio = 16'd16;
        cfg.cfg_valid = 1'b1;
        tick();
        cfg.cfg_valid = 1'b0;
        check("st_cleared", stall, 0);

        // Asynchronous reset in the middle of a flush.
        count_rst("mid_rst");
        tick();
        tick();
        check("mid_flush_din", cic_d_in, 5);
        check("mid_flush_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("mid_async");
        tick();
        tick();
        rst_n = 1'b1;
        count_rst("reboot_rst");
        wait_strobes(4, "reboot_settle", nv);
        check("reboot_novalid", nv, 0);
        wait_strobes(1, "reboot_5th", nv);
        expect_pulse("reboot_first");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cic_ctrl.md
Name: cic_ctrl

Overview:
Run-time sequencer for the CIC decimator in the AM demodulator chain. It owns the CIC's reset, decimation ratio and input gating, and accepts ratio changes from a config master through a valid/ready handshake. On each change it resets and flushes the CIC, masking transient outputs, then forwards qualified decimated samples as single-cycle valid pulses. A watchdog detects a stalled CIC output strobe and recovers automatically.

Parameters:
RATIO_W, 16, width of decimation ratio
DATA_W, 8, signed sample width (in and out)
DEFAULT_RATIO, 12500, ratio loaded at reset
MIN_RATIO, 2, smallest legal ratio; smaller values are rejected
RST_CYCLES, 4, clocks cic_rst is held per reconfiguration
SETTLE_SAMPLES, 4, CIC output strobes discarded after reset (CIC stage count)
WDOG_MARGIN, 16, slack clocks added to watchdog limit

Ports:
clk  in  1  system clock; the CIC runs on the same clock
rst_n  in  1  asynchronous active-low reset
d_in  in  DATA_W  signed input samples, one per clk
cfg_ratio  in  RATIO_W  requested decimation ratio
cfg_valid  in  1  config request
cfg_ready  out  1  config accepted when high with cfg_valid
cfg_err  out  1  one-cycle pulse on a rejected ratio
cic_rst  out  1  active-high reset to CIC
cic_ratio  out  RATIO_W  ratio driven to CIC
cic_d_in  out  DATA_W  gated, registered sample to CIC
cic_d_out  in  DATA_W  CIC output
cic_d_clk  in  1  CIC output strobe (level, synchronous to clk)
d_out  out  DATA_W  qualified decimated sample
d_out_valid  out  1  one-cycle pulse per new d_out
busy  out  1  high outside S_RUN
stall  out  1  sticky watchdog flag

Behaviour:
- Reset (rst_n low, async): state S_RST, cic_rst=1, cic_ratio=DEFAULT_RATIO, cic_d_in=0, d_out=0, d_out_valid=0, cfg_ready=0, cfg_err=0, busy=1, stall=0, all counters 0, strobe history 0. On release the block self-starts with DEFAULT_RATIO.
- Strobe edge: edge = cic_d_clk & ~prev; prev is registered every cycle in all states.
- S_RST: cic_rst=1, cic_d_in=0. After RST_CYCLES clocks, go to S_FLUSH and clear the counters.
- S_FLUSH: cic_rst=0, cic_d_in<=d_in (1-cycle latency). Count edges. After the SETTLE_SAMPLES-th edge, go to S_RUN. No d_out_valid is produced in this state.
- S_RUN: cfg_ready=1, busy=0. On edge, d_out<=cic_d_out and d_out_valid=1 on the following cycle only.
- Config handshake: transfer occurs when cfg_valid & cfg_ready.
  - cfg_ratio < MIN_RATIO: cfg_err pulses one cycle, state and cic_ratio are unchanged, cfg_ready stays high.
  - Otherwise: cic_ratio<=cfg_ratio, stall cleared, go to S_RST. cfg_ready is low from the next cycle.
  - cfg_valid outside S_RUN is held off and not lost. The master must keep cfg_valid and cfg_ratio stable until the transfer.
- Simultaneous edge and accepted config: the sample is dropped and no d_out_valid is produced.
- Watchdog: active in S_FLUSH and S_RUN.
  - Counter (RATIO_W+2 bits, saturating) counts clocks and clears on each edge.
  - When it reaches 2*cic_ratio+WDOG_MARGIN: stall<=1 (sticky), re-enter S_RST with the same cic_ratio.
  - stall is cleared only by rst_n or an accepted legal config.
- d_out holds its last value between pulses and through reconfigurations.
- Reset mid-operation: the async reset overrides every state and returns all outputs to their reset values immediately.

Decomposition:
- Package cic_pkg holds:
  - state encoding S_RST/S_FLUSH/S_RUN
  - DEFAULT_RATIO, MIN_RATIO, RATIO_W, DATA_W
- One sub-module, cic_strobe_mon. It contains the edge detector plus the watchdog counter, and provides edge and timeout outputs with a clear input.
- The FSM, handshake and gating stay in cic_ctrl.

Test Plan:
- Boot: DEFAULT_RATIO=8 (bench override), behavioural CIC strobing every 8 clks, d_in=5 constant.
  - cic_rst high for exactly 4 clks after release.
  - First 4 strobes produce no d_out_valid.
  - 5th strobe gives a d_out_valid pulse exactly 1 clk after the edge, with cfg_ready=1.
- Reconfig: in S_RUN, cfg_ratio=16 with cfg_valid.
  - cic_ratio=16 next clk, cic_rst high 4 clks, cic_d_in=0 during reset.
  - 4 strobes suppressed, then valid output resumes every 16 clks.
- Illegal ratio: cfg_ratio=1.
  - cfg_err is a single-cycle pulse, cic_ratio stays 8, no cic_rst, output stream uninterrupted.
- Held-off request: cfg_valid raised during S_FLUSH.
  - Transfer occurs on the first S_RUN cycle.
  - Coincident strobe on that cycle yields no d_out_valid.
- Stall: ratio 8, CIC model stops strobing.
  - stall=1 32 clks after the last edge, state returns to S_RST with ratio 8.
  - Restart the strobes: flush then run; stall stays 1 until a legal cfg, which clears it.
- Mid-flush reset: assert rst_n low during S_FLUSH.
  - All outputs go to reset values in the same cycle, without waiting for a clk edge.
  - After release, the full boot sequence repeats.
